// File: rtl/st_adapter_pkg.sv
// Shared constants and helpers for the streaming ready-latency adapter.
package st_adapter_pkg;

  localparam int RL_MAX     = 4;
  localparam int DROP_CNT_W = 16;

  // Ceiling log2, usable in constant expressions (clog2(1) = 0).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

  // True when value is a positive power of two.
  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/st_sync_fifo.sv
// Synchronous FIFO with combinational head read and an occupancy count.
// Pointers wrap naturally because DEPTH is a power of two.
module st_sync_fifo
  import st_adapter_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     srst_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [clog2(DEPTH):0]    count_o
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_ok;
  logic             rd_ok;

  // Next pointers and occupancy; a write into a full buffer is ignored.
  always_comb begin
    wr_ok    = wr_en_i && (count_q != CNT_W'(DEPTH));
    rd_ok    = rd_en_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (wr_ok && !rd_ok) count_d = count_q + CNT_W'(1);
    else if (!wr_ok && rd_ok) count_d = count_q - CNT_W'(1);
  end

  // Pointer and occupancy registers; reset discards all buffered entries.
  always_ff @(posedge clk) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since the count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/st_ready_latency_adapter.sv
// Converts an upstream stream with ready latency IN_RL into a ready-latency-0
// downstream stream. in_ready is issued only when every beat that may still
// arrive against an already-issued ready is guaranteed a free slot.
module st_ready_latency_adapter
  import st_adapter_pkg::*;
#(
  parameter int DATA_W    = 1,
  parameter int CHANNEL_W = 8,
  parameter int IN_RL     = 1,
  parameter int DEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [CHANNEL_W-1:0]  in_channel,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [CHANNEL_W-1:0]  out_channel,
  input  logic                  out_ready,
  output logic                  protocol_error,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam int CNT_W  = clog2(DEPTH) + 1;
  localparam int OCC_W  = CNT_W + 3;
  localparam int WARM_W = 3;
  localparam int BEAT_W = DATA_W + CHANNEL_W;

  // Reject parameter sets the ready accounting cannot support.
  generate
    if (IN_RL < 0 || IN_RL > RL_MAX) begin : g_bad_rl
      $error("IN_RL must lie within 0..%0d", RL_MAX);
    end
    if (!is_pow2(DEPTH)) begin : g_bad_depth_pow2
      $error("DEPTH must be a power of two");
    end
    if (DEPTH < IN_RL + 2) begin : g_bad_depth_rl
      $error("DEPTH must be at least IN_RL+2");
    end
    if (DATA_W < 1 || CHANNEL_W < 1) begin : g_bad_width
      $error("DATA_W and CHANNEL_W must be at least 1");
    end
  endgenerate

  // hist_q[k-1] holds in_ready as it was k cycles ago.
  logic [RL_MAX-1:0]     hist_q, hist_d;
  logic [RL_MAX-1:0]     hist_live;
  logic [WARM_W-1:0]     warm_q, warm_d;
  logic                  err_q, err_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic                  matured;
  logic                  mature_window;
  logic [2:0]            pending;
  logic [OCC_W-1:0]      occupancy;
  logic                  full;
  logic                  wr_en;
  logic                  rd_en;
  logic                  drop;
  logic [CNT_W-1:0]      count;
  logic [BEAT_W-1:0]     head;

  // Only the IN_RL most recent readies can still have beats in flight.
  generate
    for (genvar gi = 0; gi < RL_MAX; gi++) begin : g_live
      assign hist_live[gi] = (gi < IN_RL) ? hist_q[gi] : 1'b0;
    end
    if (IN_RL == 0) begin : g_rl0
      assign matured = in_ready;
    end else begin : g_rl
      assign matured = hist_q[IN_RL-1];
    end
  endgenerate

  // Ready issue: occupancy plus outstanding readies must leave a free slot.
  always_comb begin
    pending = '0;
    for (int k = 0; k < RL_MAX; k++) begin
      pending = pending + {2'b00, hist_live[k]};
    end
    occupancy = OCC_W'(count) + OCC_W'(pending);
    in_ready  = !reset && (occupancy < OCC_W'(DEPTH));
  end

  // Write/drop decision and next state of the bookkeeping registers.
  // Until IN_RL cycles have passed since reset the matured ready reflects
  // the reset period, so such beats are dropped without flagging an error.
  always_comb begin
    mature_window = (warm_q == WARM_W'(IN_RL));
    full          = (count == CNT_W'(DEPTH));
    wr_en         = in_valid && mature_window && matured && !full;
    drop          = in_valid && !wr_en;
    rd_en         = out_valid && out_ready;
    hist_d        = {hist_q[RL_MAX-2:0], in_ready};
    warm_d        = mature_window ? warm_q : warm_q + WARM_W'(1);
    err_d         = err_q || (drop && mature_window);
    drop_d        = drop_q;
    if (drop && (drop_q != '1)) drop_d = drop_q + DROP_CNT_W'(1);
  end

  // Ready history, warm-up counter and error/drop registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      warm_q <= '0;
      err_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      hist_q <= hist_d;
      warm_q <= warm_d;
      err_q  <= err_d;
      drop_q <= drop_d;
    end
  end

  st_sync_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .srst_i    (reset),
    .wr_en_i   (wr_en),
    .wr_data_i ({in_data, in_channel}),
    .rd_en_i   (rd_en),
    .rd_data_o (head),
    .count_o   (count)
  );

  assign out_valid      = (count != '0);
  assign out_data       = out_valid ? head[BEAT_W-1:CHANNEL_W] : '0;
  assign out_channel    = out_valid ? head[CHANNEL_W-1:0] : '0;
  assign protocol_error = err_q;
  assign drop_count     = drop_q;

endmodule

// File: tb/tb_st_ready_latency_adapter.sv
// Randomised scoreboard bench for st_ready_latency_adapter (IN_RL=2, DEPTH=4).
// The driver advances a queue-based reference model once per cycle and
// queues expected beats; the monitor compares DUT outputs on the falling edge.
module tb_st_ready_latency_adapter;

  localparam int DATA_W    = 8;
  localparam int CHANNEL_W = 8;
  localparam int IN_RL     = 2;
  localparam int DEPTH     = 4;
  localparam int BEAT_W    = DATA_W + CHANNEL_W;

  localparam int M_COMPLIANT = 0;  // valid at random, only against matured ready
  localparam int M_STREAM    = 1;  // valid whenever ready has matured
  localparam int M_RANDOM    = 2;  // valid at random, ignoring ready
  localparam int M_ALWAYS    = 3;  // valid every cycle
  localparam int M_IDLE      = 4;  // never valid

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  in_valid;
  logic [DATA_W-1:0]     in_data;
  logic [CHANNEL_W-1:0]  in_channel;
  logic                  in_ready;
  logic                  out_valid;
  logic [DATA_W-1:0]     out_data;
  logic [CHANNEL_W-1:0]  out_channel;
  logic                  out_ready;
  logic                  protocol_error;
  logic [15:0]           drop_count;

  always #5 clk = ~clk;

  st_ready_latency_adapter #(
    .DATA_W    (DATA_W),
    .CHANNEL_W (CHANNEL_W),
    .IN_RL     (IN_RL),
    .DEPTH     (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_channel     (in_channel),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_channel    (out_channel),
    .out_ready      (out_ready),
    .protocol_error (protocol_error),
    .drop_count     (drop_count)
  );

  typedef struct packed {
    logic ready;  // in_ready value issued that cycle
    logic stale;  // that cycle was spent in reset
  } hist_t;

  logic [BEAT_W-1:0] sb[$];    // beats expected in the buffer, oldest first
  hist_t             hist[$];  // last IN_RL issued readies, oldest first

  bit                exp_ready;
  bit                exp_err;
  int                exp_drops;
  bit                next_push_v;
  logic [BEAT_W-1:0] next_push;
  bit                next_err;
  int                next_drops;
  bit                prev_rst;
  bit                mon_en;
  bit                verbose;
  int                chan_ctr;
  int                beats_out;
  int                errors;
  int                checks;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic init_hist();
    hist.delete();
    for (int i = 0; i < IN_RL; i++) hist.push_back(hist_t'{ready: 1'b0, stale: 1'b1});
  endtask

  // One clock cycle: commit last cycle's model effects, then drive and predict.
  task automatic step(input bit rst, input int mode, input int rdy_pct);
    int pend;
    bit stale;
    bit mat;
    bit v;
    @(posedge clk);
    #1;
    if (prev_rst) begin
      sb.delete();
      init_hist();
      exp_err   = 1'b0;
      exp_drops = 0;
    end else begin
      if (next_push_v) sb.push_back(next_push);
      exp_err   = next_err;
      exp_drops = next_drops;
    end
    reset = rst;
    pend = 0;
    foreach (hist[i]) pend += int'(hist[i].ready);
    exp_ready = !rst && ((sb.size() + pend) < DEPTH);
    stale = hist[0].stale;
    mat   = hist[0].ready;
    case (mode)
      M_COMPLIANT: v = mat && ($urandom_range(99) < 70);
      M_STREAM:    v = mat;
      M_RANDOM:    v = ($urandom_range(99) < 50);
      M_ALWAYS:    v = 1'b1;
      default:     v = 1'b0;
    endcase
    in_valid   = v;
    in_data    = DATA_W'($urandom);
    in_channel = CHANNEL_W'(chan_ctr);
    out_ready  = ($urandom_range(99) < rdy_pct);
    next_push_v = 1'b0;
    next_push   = {in_data, in_channel};
    next_err    = exp_err;
    next_drops  = exp_drops;
    if (!rst && v) begin
      if (!stale && mat && (sb.size() < DEPTH)) begin
        next_push_v = 1'b1;
      end else begin
        if (!stale) next_err = 1'b1;
        if (next_drops < 16'hFFFF) next_drops++;
      end
    end
    if (v) chan_ctr++;
    void'(hist.pop_front());
    hist.push_back(hist_t'{ready: exp_ready, stale: rst});
    prev_rst = rst;
  endtask

  task automatic run(input int n, input int mode, input int rdy_pct);
    for (int i = 0; i < n; i++) step(1'b0, mode, rdy_pct);
  endtask

  // Monitor: compare every DUT output against the model each cycle.
  initial begin : monitor
    logic [BEAT_W-1:0] head;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
          head = sb[0];
          chk("out_channel", 32'(out_channel), 32'(head[CHANNEL_W-1:0]));
          chk("out_data", 32'(out_data), 32'(head[BEAT_W-1:CHANNEL_W]));
        end else begin
          chk("out_payload_empty", 32'({out_data, out_channel}), 32'(0));
        end
        chk("protocol_error", 32'(protocol_error), 32'(exp_err));
        chk("drop_count", 32'(drop_count), 32'(exp_drops));
        if ((sb.size() != 0) && out_ready) begin
          head = sb.pop_front();
          beats_out++;
          if (verbose)
            $display("beat %0d out: channel=%0h data=%0h", beats_out,
                     head[CHANNEL_W-1:0], head[BEAT_W-1:CHANNEL_W]);
        end
      end
    end
  end

  initial begin : driver
    errors = 0; checks = 0; beats_out = 0; chan_ctr = 0;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_channel = '0; out_ready = 1'b0;
    prev_rst = 1'b1; verbose = 1'b1; mon_en = 1'b0;
    exp_err = 1'b0; exp_drops = 0; next_err = 1'b0; next_drops = 0; next_push_v = 1'b0;
    init_hist();

    // Reset with beats offered throughout: all ignored.
    step(1'b1, M_ALWAYS, 0);
    mon_en = 1'b1;
    step(1'b1, M_ALWAYS, 0);
    step(1'b1, M_ALWAYS, 0);

    // Streaming: one beat per cycle once ready has matured, channels 0..
    chan_ctr = 0;
    run(14, M_STREAM, 100);

    // Fill with downstream stalled, then drain.
    run(10, M_STREAM, 0);
    run(6, M_IDLE, 100);

    // Full buffer, then read every cycle while upstream keeps writing.
    run(8, M_STREAM, 0);
    run(14, M_STREAM, 100);
    run(4, M_IDLE, 100);

    // Upstream ignoring ready: drops and sticky error.
    run(40, M_RANDOM, 50);
    run(6, M_IDLE, 100);

    // Reset with three beats buffered.
    step(1'b1, M_IDLE, 0);
    run(5, M_STREAM, 0);
    step(1'b1, M_IDLE, 0);
    run(4, M_IDLE, 0);

    // Beats offered before ready has matured after reset.
    step(1'b1, M_IDLE, 0);
    run(6, M_ALWAYS, 100);
    run(4, M_IDLE, 100);

    // Random soak with occasional reset pulses.
    for (int i = 0; i < 2000; i++) begin
      int m;
      m = ($urandom_range(9) < 8) ? M_COMPLIANT : M_RANDOM;
      step($urandom_range(99) == 0, m, int'($urandom_range(100)));
    end

    // Saturate drop_count by keeping the buffer full under a constant stream.
    step(1'b1, M_IDLE, 0);
    verbose = 1'b0;
    run(65545, M_ALWAYS, 0);
    @(negedge clk);
    chk("drop_count_saturated", 32'(drop_count), 32'h0000_FFFF);
    run(20, M_ALWAYS, 0);
    @(negedge clk);
    chk("drop_count_held", 32'(drop_count), 32'h0000_FFFF);
    verbose = 1'b1;
    run(6, M_IDLE, 100);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
